// File: rtl/color_analyzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : color_analyzer_pkg
// Description : Shared FSM encoding, colour codes and RGB332 field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package color_analyzer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef logic [1:0] color_code_t;

    localparam color_code_t COLOR_NONE  = 2'b00;
    localparam color_code_t COLOR_RED   = 2'b01;
    localparam color_code_t COLOR_GREEN = 2'b10;
    localparam color_code_t COLOR_BLUE  = 2'b11;

    localparam int PIX_R_HI = 7;
    localparam int PIX_R_LO = 5;
    localparam int PIX_G_HI = 4;
    localparam int PIX_G_LO = 2;
    localparam int PIX_B_HI = 1;
    localparam int PIX_B_LO = 0;

    // Blue has only two bits; replicate its MSB so it spans the same 0..7 range.
    function automatic logic [2:0] scale_blue(input logic [1:0] b);
        return {b, b[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/color_analyzer_pixel_classifier.sv
`default_nettype none
// ============================================================================
// Module      : pixel_classifier
// Description : Combinational RGB332 pixel to dominant-colour classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_classifier
    import color_analyzer_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] pixel_i,
    output logic [1:0]    class_o
);

    logic [2:0] w_r;
    logic [2:0] w_g;
    logic [2:0] w_b;

    assign w_r = pixel_i[PIX_R_HI:PIX_R_LO];
    assign w_g = pixel_i[PIX_G_HI:PIX_G_LO];
    assign w_b = scale_blue(pixel_i[PIX_B_HI:PIX_B_LO]);

    // Strict comparisons make every tie fall through to "no class".
    always_comb begin
        class_o = COLOR_NONE;
        if ((w_r > w_g) && (w_r > w_b) && (w_r >= 3'd4)) begin
            class_o = COLOR_RED;
        end else if ((w_g > w_r) && (w_g > w_b) && (w_g >= 3'd4)) begin
            class_o = COLOR_GREEN;
        end else if ((w_b > w_r) && (w_b > w_g) && (w_b >= 3'd4)) begin
            class_o = COLOR_BLUE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/color_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : color_analyzer
// Description : Scans a stored frame, counts red/green/blue pixels, decides colour.
// Revision    : 1.0 - initial release
// ============================================================================
module color_analyzer
    import color_analyzer_pkg::*;
#(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int DW           = 8,
    parameter int MIN_COUNT    = 1920
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    color_code,
    output logic [AW-1:0] cnt_r,
    output logic [AW-1:0] cnt_g,
    output logic [AW-1:0] cnt_b
);

    localparam int            C_NPIX = CAM_SCREEN_X * CAM_SCREEN_Y;
    localparam logic [AW-1:0] C_LAST = AW'(C_NPIX - 1);
    localparam logic [AW-1:0] C_MIN  = AW'(MIN_COUNT);

    generate
        if ((longint'(CAM_SCREEN_X) * longint'(CAM_SCREEN_Y)) >= (longint'(1) << AW)) begin : g_size_check
            $error("color_analyzer: frame size does not fit in AW-bit counters");
        end
    endgenerate

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [AW-1:0] addr_q;
    logic          vld_q;
    logic [AW-1:0] cnt_r_q;
    logic [AW-1:0] cnt_g_q;
    logic [AW-1:0] cnt_b_q;
    logic [1:0]    code_q;

    logic [1:0]    w_class;
    logic [1:0]    w_best_code;
    logic [AW-1:0] w_best_cnt;
    logic [1:0]    w_code;

    pixel_classifier #(
        .DW (DW)
    ) u_classifier (
        .pixel_i (mem_data),
        .class_o (w_class)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_READ;
            ST_READ:   if (addr_q == C_LAST) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strict '>' keeps the earlier class on equal counts: red > green > blue.
    always_comb begin
        w_best_code = COLOR_RED;
        w_best_cnt  = cnt_r_q;
        if (cnt_g_q > w_best_cnt) begin
            w_best_code = COLOR_GREEN;
            w_best_cnt  = cnt_g_q;
        end
        if (cnt_b_q > w_best_cnt) begin
            w_best_code = COLOR_BLUE;
            w_best_cnt  = cnt_b_q;
        end
        w_code = (w_best_cnt >= C_MIN) ? w_best_code : COLOR_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
            code_q  <= COLOR_NONE;
        end else begin
            state_q <= state_d;
            // mem_data is valid for the address issued in the previous READ cycle.
            vld_q   <= (state_q == ST_READ);

            if ((state_q == ST_IDLE) && start) begin
                addr_q  <= '0;
                cnt_r_q <= '0;
                cnt_g_q <= '0;
                cnt_b_q <= '0;
            end else if ((state_q == ST_READ) && (addr_q != C_LAST)) begin
                addr_q <= addr_q + AW'(1);
            end

            if (vld_q) begin
                case (w_class)
                    COLOR_RED:   cnt_r_q <= cnt_r_q + AW'(1);
                    COLOR_GREEN: cnt_g_q <= cnt_g_q + AW'(1);
                    COLOR_BLUE:  cnt_b_q <= cnt_b_q + AW'(1);
                    default:     ;
                endcase
            end

            if (state_q == ST_DECIDE) begin
                code_q <= w_code;
            end
        end
    end

    assign mem_addr   = addr_q;
    assign busy       = (state_q == ST_READ) || (state_q == ST_DRAIN) || (state_q == ST_DECIDE);
    assign done       = (state_q == ST_DONE);
    assign color_code = code_q;
    assign cnt_r      = cnt_r_q;
    assign cnt_g      = cnt_g_q;
    assign cnt_b      = cnt_b_q;

endmodule
`default_nettype wire

// File: tb/tb_color_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : tb_color_analyzer
// Description : Self-checking bench for color_analyzer on a reduced 40x30 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_color_analyzer;

    localparam int SX       = 40;
    localparam int SY       = 30;
    localparam int NPIX     = SX * SY;
    localparam int AW       = 11;
    localparam int MINC     = NPIX / 10;
    localparam int LAT      = NPIX + 4;
    localparam int ABORT_AT = NPIX / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data = 8'h00;
    logic          busy;
    logic          done;
    logic [1:0]    color_code;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_g;
    logic [AW-1:0] cnt_b;

    logic [7:0] fb [NPIX];
    int total = 0;
    int bad   = 0;

    color_analyzer #(
        .CAM_SCREEN_X (SX),
        .CAM_SCREEN_Y (SY),
        .AW           (AW),
        .DW           (8),
        .MIN_COUNT    (MINC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .color_code (color_code),
        .cnt_r      (cnt_r),
        .cnt_g      (cnt_g),
        .cnt_b      (cnt_b)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (int'(mem_addr) < NPIX) mem_data <= fb[int'(mem_addr)];
        else                       mem_data <= 8'h00;
    end

    // Class of one pixel: the unique strongest channel if it is at least 4.
    function automatic int ref_class(input logic [7:0] p);
        int ch [3];
        int mx, nmx, who;
        ch[0] = int'(p[7:5]);
        ch[1] = int'(p[4:2]);
        ch[2] = int'({p[1:0], p[1]});
        mx = 0; nmx = 0; who = 0;
        for (int k = 0; k < 3; k++) if (ch[k] > mx) mx = ch[k];
        for (int k = 0; k < 3; k++) if (ch[k] == mx) begin nmx++; who = k; end
        if (nmx == 1 && mx >= 4) return who + 1;
        return 0;
    endfunction

    task automatic fill_split(input logic [7:0] a, input int na, input logic [7:0] b);
        for (int i = 0; i < NPIX; i++) fb[i] = (i < na) ? a : b;
    endtask

    task automatic fill_random();
        logic [7:0] dom;
        dom = 8'($urandom);
        for (int i = 0; i < NPIX; i++)
            fb[i] = ($urandom_range(1, 0) == 1) ? dom : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_scan(input string name, input int extra_at, input int lit_code);
        int c [4];
        int best, exp_code, idx, done_idx, ndone;
        logic busy_at_done, busy_first;
        for (int k = 0; k < 4; k++) c[k] = 0;
        for (int i = 0; i < NPIX; i++) c[ref_class(fb[i])]++;
        best = 1;
        for (int k = 2; k <= 3; k++) if (c[k] > c[best]) best = k;
        exp_code = (c[best] >= MINC) ? best : 0;

        done_idx = 0; ndone = 0; busy_at_done = 1'b1; busy_first = 1'b0;
        start = 1'b1;
        tick();
        for (idx = 2; idx <= LAT + 8; idx++) begin
            if (idx == 2) busy_first = busy;
            if (done) begin
                ndone++;
                if (done_idx == 0) begin done_idx = idx; busy_at_done = busy; end
            end
            start = (idx == extra_at) || (extra_at > 0 && done);
            tick();
        end
        start = 1'b0;

        total++; if (busy_first !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_first); end
        total++; if (done_idx != LAT) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, done_idx, LAT); end
        total++; if (ndone != 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", name, ndone); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL %s busy_in_done: got %b want 0", name, busy_at_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
        total++; if (cnt_r !== AW'(c[1])) begin bad++; $display("FAIL %s cnt_r: got %0d want %0d", name, cnt_r, c[1]); end
        total++; if (cnt_g !== AW'(c[2])) begin bad++; $display("FAIL %s cnt_g: got %0d want %0d", name, cnt_g, c[2]); end
        total++; if (cnt_b !== AW'(c[3])) begin bad++; $display("FAIL %s cnt_b: got %0d want %0d", name, cnt_b, c[3]); end
        total++; if (color_code !== 2'(exp_code)) begin bad++; $display("FAIL %s color_code: got %0d want %0d", name, color_code, exp_code); end
        if (lit_code >= 0) begin
            total++; if (color_code !== 2'(lit_code)) begin bad++; $display("FAIL %s color_code_lit: got %0d want %0d", name, color_code, lit_code); end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset mem_addr: got %0d want 0", mem_addr); end
        total++; if (color_code !== 2'b00) begin bad++; $display("FAIL reset color_code: got %0d want 0", color_code); end
        total++; if ({cnt_r, cnt_g, cnt_b} !== '0) begin bad++; $display("FAIL reset counts: got %0d/%0d/%0d want 0", cnt_r, cnt_g, cnt_b); end
        rst = 1'b0; start = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_directed();
        fill_split(8'hE0, NPIX, 8'h00);            run_scan("all_red", 0, 1);
        fill_split(8'h1C, 625, 8'h03);             run_scan("green_blue", 0, 2);
        fill_split(8'h00, NPIX, 8'h00);            run_scan("all_black", 0, 0);
        fill_split(8'hFF, NPIX, 8'hFF);            run_scan("all_white", 0, 0);
        fill_split(8'hE0, MINC - 1, 8'h00);        run_scan("below_min", 0, 0);
        fill_split(8'hE0, MINC, 8'h00);            run_scan("at_min", 0, 1);
        fill_split(8'hE0, NPIX / 2, 8'h1C);        run_scan("tie_rg", 0, 1);
        fill_split(8'h1C, NPIX / 2, 8'h03);        run_scan("tie_gb", 0, 2);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            fill_random();
            run_scan("random", 0, -1);
        end
    endtask

    task automatic test_extra_start();
        fill_random();
        run_scan("extra_start", 100, -1);
    endtask

    task automatic test_abort();
        int ndone;
        fill_split(8'hE0, NPIX, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int idx = 2; idx < ABORT_AT; idx++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", busy); end
        total++; if ({cnt_r, cnt_g, cnt_b} !== '0) begin bad++; $display("FAIL abort counts: got %0d/%0d/%0d want 0", cnt_r, cnt_g, cnt_b); end
        total++; if (color_code !== 2'b00) begin bad++; $display("FAIL abort color_code: got %0d want 0", color_code); end
        ndone = 0;
        for (int i = 0; i < LAT; i++) begin
            if (done) ndone++;
            tick();
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL abort no_done: got %0d want 0", ndone); end
        fill_split(8'h03, NPIX, 8'h00);
        run_scan("after_abort", 0, 3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < NPIX; i++) fb[i] = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_extra_start();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/color_analyzer.md
COLOR_ANALYZER -- requirements
Module: color_analyzer

Interface
REQ-001 Parameter CAM_SCREEN_X, default 160, frame width in pixels.
REQ-002 Parameter CAM_SCREEN_Y, default 120, frame height in pixels.
REQ-003 Parameter AW, default 15, frame-buffer address width.
REQ-004 Parameter DW, default 8, pixel width, RGB 332.
REQ-005 Parameter MIN_COUNT, default 1920, minimum class count for a valid decision (10% of frame).
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock, 25 MHz read-side domain of the frame buffer.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 start  input  1  single-cycle request to analyse the stored frame.
REQ-010 mem_addr  output  AW  frame-buffer read address.
REQ-011 mem_data  input  DW  frame-buffer read data, valid exactly 1 cycle after mem_addr.
REQ-012 busy  output  1  high while a scan is in progress.
REQ-013 done  output  1  single-cycle pulse when results are updated.
REQ-014 color_code  output  2  00 none, 01 red, 10 green, 11 blue.
REQ-015 cnt_r, cnt_g, cnt_b  output  AW each  per-class pixel counts of the last scan.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, DECIDE, DONE.
REQ-017 IDLE -> READ on start; count registers cleared on that same edge; busy=1 from the next cycle.
REQ-018 READ: mem_addr = 0 on the first READ cycle, then +1 each cycle up to N-1, where N = CAM_SCREEN_X*CAM_SCREEN_Y (19200).
REQ-019 READ -> DRAIN after address N-1 is issued; DRAIN lasts 1 cycle to accumulate the last pixel.
REQ-020 Pixel accumulation uses the data returned for the address issued in the previous cycle; each address is counted exactly once.
REQ-021 Classification uses R=mem_data[7:5], G=mem_data[4:2], and Bs={mem_data[1:0],mem_data[1]} (3-bit scaled blue).
REQ-022 Red class: R>G, R>Bs, and R>=4.
REQ-023 Green class: G>R, G>Bs, and G>=4.
REQ-024 Blue class: Bs>R, Bs>G, and Bs>=4.
REQ-025 A pixel matching no class, including any tie, is not counted.
REQ-026 Counters are AW bits wide and cannot overflow, because N < 2^AW; a generic N >= 2^AW is illegal (elaboration error).
REQ-027 DECIDE (1 cycle): color_code = class with the largest count if that count >= MIN_COUNT, else 00.
REQ-028 DECIDE tie priority: red > green > blue.
REQ-029 DONE: done=1 for exactly 1 cycle, busy falls in the same cycle, then -> IDLE.
REQ-030 Latency: done is asserted N+4 cycles after the start edge (19204 at default).
REQ-031 start while busy=1 or during DONE is ignored.
REQ-032 cnt_r, cnt_g, cnt_b, and color_code hold their values from DONE until the next accepted start.
REQ-033 mem_addr holds its last value outside READ.

Reset
REQ-034 On rst=1 at a clk edge: state=IDLE, mem_addr=0, busy=0, done=0, color_code=00, and all counts=0.
REQ-035 rst mid-scan aborts the scan with no done pulse; partial counts are discarded.
REQ-036 rst has priority over a simultaneous start.

Structure
REQ-037 A shared package holds the FSM state encoding, the color_code constants (NONE/RED/GREEN/BLUE), and the RGB 332 field positions, for reuse by the VGA overlay logic.
REQ-038 One combinational sub-module, pixel_classifier (DW-bit pixel in, 2-bit class out), implements REQ-021 to REQ-025.

Verification
REQ-039 Buffer model all 8'hE0, pulse start -> done at cycle +19204, cnt_r=19200, cnt_g=0, cnt_b=0, color_code=01.
REQ-040 Frame of 10000 x 8'h1C and 9200 x 8'h03 -> cnt_g=10000, cnt_b=9200, color_code=10.
REQ-041 All pixels 8'h00, then all 8'hFF -> all counts 0 and color_code=00 in both runs.
REQ-042 Frame with 1919 x 8'hE0 and the rest 8'h00 -> cnt_r=1919, color_code=00; repeat with 1920 -> color_code=01.
REQ-043 Frame with 9600 red and 9600 green -> color_code=01 (tie priority).
REQ-044 Extra start at cycle 100 of a scan -> ignored, single done; rst at cycle 5000 -> busy=0 next cycle, no done, counts 0; a fresh start then completes normally.
